// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with per-entry busy (pending producer) bits.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] dout0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] dout1,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] din0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] din1,
    input  logic              bset,
    input  logic [ADDR_W-1:0] baddr,
    output logic              busy0,
    output logic              busy1
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NRD   = 2;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic                         wok0, wok1, bok;

    // Entry 0 is never written or marked busy when it is the hardwired zero register.
    assign wok0 = we0  && !(ZERO_REG != 0 && waddr0 == '0);
    assign wok1 = we1  && !(ZERO_REG != 0 && waddr1 == '0);
    assign bok  = bset && !(ZERO_REG != 0 && baddr  == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            if (wok0) begin
                mem[waddr0]  <= din0;
                busy[waddr0] <= 1'b0;
            end
            if (wok1) begin
                mem[waddr1]  <= din1;
                busy[waddr1] <= 1'b0;
            end
            if (bok)
                busy[baddr] <= 1'b1;
        end
    end

    logic [NRD-1:0][ADDR_W-1:0] raddr;
    logic [NRD-1:0][DATA_W-1:0] dout;
    logic [NRD-1:0]             busy_rd;

    assign raddr = {raddr1, raddr0};
    assign dout0 = dout[0];
    assign dout1 = dout[1];
    assign busy0 = busy_rd[0];
    assign busy1 = busy_rd[1];

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        always_comb begin
            dout[p]    = mem[raddr[p]];
            busy_rd[p] = busy[raddr[p]];
`ifdef RF_BYPASS_EN
            if (!rst) begin
                if (wok1 && waddr1 == raddr[p])
                    dout[p] = din1;
                else if (wok0 && waddr0 == raddr[p])
                    dout[p] = din0;
                // A same-cycle write retires the producer unless a new one claims the entry.
                if (((wok0 && waddr0 == raddr[p]) || (wok1 && waddr1 == raddr[p])) &&
                    !(bok && baddr == raddr[p]))
                    busy_rd[p] = 1'b0;
            end
`endif
            if (ZERO_REG != 0 && raddr[p] == '0) begin
                dout[p]    = '0;
                busy_rd[p] = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_2w2r.sv
// Scoreboard bench for regfile_2w2r: expected read results are queued when inputs are
// driven and popped when the combinational outputs are sampled mid-cycle.
module tb_regfile_2w2r;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] raddr0, raddr1, waddr0, waddr1, baddr;
    logic [DATA_W-1:0] dout0, dout1, din0, din1;
    logic              we0, we1, bset, busy0, busy1;

    regfile_2w2r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .raddr0(raddr0), .dout0(dout0), .raddr1(raddr1), .dout1(dout1),
        .we0(we0), .waddr0(waddr0), .din0(din0),
        .we1(we1), .waddr1(waddr1), .din1(din1),
        .bset(bset), .baddr(baddr), .busy0(busy0), .busy1(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic              b0;
        logic              b1;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_busy[DEPTH];
    int                n_chk = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_dout(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (!rst && we1 && waddr1 == a) return din1;
        if (!rst && we0 && waddr0 == a) return din0;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (!rst && ((we0 && waddr0 == a) || (we1 && waddr1 == a)) && !(bset && baddr == a))
            return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            if (we0 && waddr0 != 0) begin m_mem[waddr0] = din0; m_busy[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin m_mem[waddr1] = din1; m_busy[waddr1] = 1'b0; end
            if (bset && baddr != 0) m_busy[baddr] = 1'b1;
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; bset = 0;
        waddr0 = '0; waddr1 = '0; baddr = '0; din0 = '0; din1 = '0;
    endtask

    // One cycle: queue the expectation, sample mid-cycle, then advance the model on the edge.
    task automatic step(input string tag);
        exp_t e;
        e.d0 = exp_dout(raddr0);
        e.d1 = exp_dout(raddr1);
        e.b0 = exp_busy(raddr0);
        e.b1 = exp_busy(raddr1);
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        chk({tag, ".dout0"}, 64'(dout0), 64'(e.d0));
        chk({tag, ".dout1"}, 64'(dout1), 64'(e.d1));
        chk({tag, ".busy0"}, 64'(busy0), 64'(e.b0));
        chk({tag, ".busy1"}, 64'(busy1), 64'(e.b1));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1; raddr0 = '0; raddr1 = '0;
        idle();
        @(posedge clk);
        model_clear();
        #1;
        step("rst_hold");
        rst = 0;

        for (int a = 0; a < DEPTH; a++) begin
            raddr0 = ADDR_W'(a); raddr1 = ADDR_W'(DEPTH - 1 - a);
            step("reset_read");
            chk("reset_const0", 64'(dout0), 64'd0);
        end

        we0 = 1; waddr0 = 5; din0 = 32'h11; we1 = 1; waddr1 = 6; din1 = 32'h22;
        step("dual_wr");
        idle(); raddr0 = 5; raddr1 = 6;
        step("dual_rd");
        chk("dual_const0", 64'(dout0), 64'h11);
        chk("dual_const1", 64'(dout1), 64'h22);

        we0 = 1; waddr0 = 9; din0 = 32'hAAAA; we1 = 1; waddr1 = 9; din1 = 32'hBBBB;
        step("conflict_wr");
        idle(); raddr0 = 9; raddr1 = 9;
        step("conflict_rd");
        chk("conflict_const", 64'(dout0), 64'hBBBB);

        we0 = 1; waddr0 = 0; din0 = 32'hFFFF_FFFF; bset = 1; baddr = 0; raddr0 = 0;
        step("zero_wr");
        idle();
        step("zero_rd");
        chk("zero_dout", 64'(dout0), 64'd0);
        chk("zero_busy", 64'(busy0), 64'd0);

        raddr0 = 7; bset = 1; baddr = 7;
        step("sb_set");
        idle();
        step("sb_busy");
        chk("sb_busy_const", 64'(busy0), 64'd1);
        we1 = 1; waddr1 = 7; din1 = 32'h77;
        step("sb_clr");
        idle();
        step("sb_cleared");
        chk("sb_cleared_const", 64'(busy0), 64'd0);
        bset = 1; baddr = 7; we0 = 1; waddr0 = 7; din0 = 32'h78;
        step("sb_both");
        idle();
        step("sb_both_after");
        chk("sb_both_const", 64'(busy0), 64'd1);

        raddr0 = 3; we0 = 1; waddr0 = 3; din0 = 32'h1234;
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_const", 64'(dout0), 64'h1234);
`else
        chk("nobypass_const", 64'(dout0), 64'd0);
`endif
        step("bypass");
        idle();
        step("bypass_after");

        for (int i = 0; i < 300; i++) begin
            rst    = ($urandom_range(0, 29) == 0);
            we0    = 1'($urandom); waddr0 = ADDR_W'($urandom_range(0, 7)); din0 = $urandom;
            we1    = 1'($urandom); waddr1 = ADDR_W'($urandom_range(0, 7)); din1 = $urandom;
            bset   = 1'($urandom); baddr  = ADDR_W'($urandom_range(0, 7));
            raddr0 = ADDR_W'($urandom_range(0, 7)); raddr1 = ADDR_W'($urandom_range(0, 7));
            step("rand");
        end
        rst = 0;

        for (int a = 1; a < 8; a++) begin
            idle(); bset = 1; baddr = ADDR_W'(a); we0 = 1; waddr0 = ADDR_W'(a + 8); din0 = $urandom;
            step("mid_fill");
        end
        idle(); rst = 1;
        step("mid_rst");
        rst = 0;
        for (int a = 0; a < 16; a++) begin
            raddr0 = ADDR_W'(a); raddr1 = ADDR_W'(a);
            step("mid_after");
            chk("mid_busy_const", 64'(busy0), 64'd0);
            chk("mid_dout_const", 64'(dout1), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
